// File: rtl/dispatch_queue.sv
// In-order 4-wide dispatch queue between rename and issue.
// Ports: enq_* group in, disp_* group out, cdb_* snoop, rs_free_i limit, count_o.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned RS_DEPTH;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{XLEN: 32, RS_DEPTH: 16};

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] fu;
  } uop_t;

endpackage

module dispatch_queue
  import config_pkg::*;
#(
  parameter cfg_t        Cfg    = EmptyCfg,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = Cfg.XLEN,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned CDB_W  = 4,
  parameter int unsigned FREE_W = $clog2(Cfg.RS_DEPTH + 1),
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic [3:0]                    enq_valid_i,
  input  uop_t [3:0]                    enq_op_i,
  input  logic [3:0][TAG_W-1:0]         enq_dst_i,
  input  logic [3:0][DATA_W-1:0]        enq_v1_i,
  input  logic [3:0][TAG_W-1:0]         enq_q1_i,
  input  logic [3:0]                    enq_r1_i,
  input  logic [3:0][DATA_W-1:0]        enq_v2_i,
  input  logic [3:0][TAG_W-1:0]         enq_q2_i,
  input  logic [3:0]                    enq_r2_i,
  output logic                          enq_ready_o,
  input  logic [CDB_W-1:0]              cdb_valid_i,
  input  logic [CDB_W-1:0][TAG_W-1:0]   cdb_tag_i,
  input  logic [CDB_W-1:0][DATA_W-1:0]  cdb_val_i,
  input  logic [FREE_W-1:0]             rs_free_i,
  output logic [3:0]                    disp_valid_o,
  output uop_t [3:0]                    disp_op_o,
  output logic [3:0][TAG_W-1:0]         disp_dst_o,
  output logic [3:0][DATA_W-1:0]        disp_v1_o,
  output logic [3:0][TAG_W-1:0]         disp_q1_o,
  output logic [3:0]                    disp_r1_o,
  output logic [3:0][DATA_W-1:0]        disp_v2_o,
  output logic [3:0][TAG_W-1:0]         disp_q2_o,
  output logic [3:0]                    disp_r2_o,
  output logic [CW-1:0]                 count_o
);

  logic [PW-1:0]                  head_q, tail_q;
  logic [CW-1:0]                  count_q, count_d;
  logic [DEPTH-1:0]               valid_q, valid_d;
  uop_t [DEPTH-1:0]               op_q, op_d;
  logic [DEPTH-1:0][TAG_W-1:0]    dst_q, dst_d;
  logic [DEPTH-1:0][DATA_W-1:0]   v1_q, v1_d, v2_q, v2_d;
  logic [DEPTH-1:0][TAG_W-1:0]    q1_q, q1_d, q2_q, q2_d;
  logic [DEPTH-1:0]               r1_q, r1_d, r2_q, r2_d;

  logic [2:0] n_enq, n_disp;
  logic       enq_fire;

  // {ready, value} after a same-cycle CDB match; lowest port wins.
  function automatic logic [DATA_W:0] wake(
    input logic              r,
    input logic [DATA_W-1:0] v,
    input logic [TAG_W-1:0]  q
  );
    logic [DATA_W:0] res;
    res = {r, v};
    if (!r) begin
      for (int c = CDB_W - 1; c >= 0; c--) begin
        if (cdb_valid_i[c] && cdb_tag_i[c] == q)
          res = {1'b1, cdb_val_i[c]};
      end
    end
    return res;
  endfunction

  assign enq_ready_o = (count_q <= CW'(DEPTH - 4));
  assign count_o     = count_q;
  assign enq_fire    = enq_ready_o & (|enq_valid_i) & ~flush_i;

  always_comb begin
    int unsigned nd;
    n_enq = '0;
    for (int k = 0; k < 4; k++)
      n_enq = n_enq + {2'b0, enq_valid_i[k]};
    nd = 32'(count_q);
    if (nd > 4) nd = 4;
    if (32'(rs_free_i) < nd) nd = 32'(rs_free_i);
    n_disp = flush_i ? 3'd0 : 3'(nd);
  end

  // Head window with combinational wakeup so a uop leaves ready.
  always_comb begin
    logic [PW-1:0] idx;
    for (int k = 0; k < 4; k++) begin
      idx = head_q + PW'(k);
      disp_valid_o[k] = (3'(k) < n_disp);
      disp_op_o[k]    = op_q[idx];
      disp_dst_o[k]   = dst_q[idx];
      disp_q1_o[k]    = q1_q[idx];
      disp_q2_o[k]    = q2_q[idx];
      {disp_r1_o[k], disp_v1_o[k]} = wake(r1_q[idx], v1_q[idx], q1_q[idx]);
      {disp_r2_o[k], disp_v2_o[k]} = wake(r2_q[idx], v2_q[idx], q2_q[idx]);
    end
  end

  always_comb begin
    logic [PW-1:0] idx;
    valid_d = valid_q;
    op_d    = op_q;
    dst_d   = dst_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        {r1_d[i], v1_d[i]} = wake(r1_q[i], v1_q[i], q1_q[i]);
        {r2_d[i], v2_d[i]} = wake(r2_q[i], v2_q[i], q2_q[i]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      idx = head_q + PW'(k);
      if (3'(k) < n_disp) valid_d[idx] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      idx = tail_q + PW'(k);
      if (enq_fire && enq_valid_i[k]) begin
        valid_d[idx] = 1'b1;
        op_d[idx]    = enq_op_i[k];
        dst_d[idx]   = enq_dst_i[k];
        q1_d[idx]    = enq_q1_i[k];
        q2_d[idx]    = enq_q2_i[k];
        {r1_d[idx], v1_d[idx]} = wake(enq_r1_i[k], enq_v1_i[k], enq_q1_i[k]);
        {r2_d[idx], v2_d[idx]} = wake(enq_r2_i[k], enq_v2_i[k], enq_q2_i[k]);
      end
    end
    count_d = count_q + CW'(enq_fire ? n_enq : 3'd0) - CW'(n_disp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_q + PW'(n_disp);
      tail_q  <= tail_q + PW'(enq_fire ? n_enq : 3'd0);
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    dst_q <= dst_d;
    q1_q  <= q1_d;
    q2_q  <= q2_d;
    v1_q  <= v1_d;
    v2_q  <= v2_d;
    r1_q  <= r1_d;
    r2_q  <= r2_d;
  end

  a_enq_contig: assert property (@(posedge clk) disable iff (!rst_n)
    enq_valid_i inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue.
// One task per scenario; inline checks; single summary line.
module tb_dispatch_queue;
  import config_pkg::*;

  logic                 clk = 0;
  logic                 rst_n;
  logic                 flush_i;
  logic [3:0]           enq_valid_i;
  uop_t [3:0]           enq_op_i;
  logic [3:0][5:0]      enq_dst_i, enq_q1_i, enq_q2_i;
  logic [3:0][31:0]     enq_v1_i, enq_v2_i;
  logic [3:0]           enq_r1_i, enq_r2_i;
  logic                 enq_ready_o;
  logic [3:0]           cdb_valid_i;
  logic [3:0][5:0]      cdb_tag_i;
  logic [3:0][31:0]     cdb_val_i;
  logic [4:0]           rs_free_i;
  logic [3:0]           disp_valid_o;
  uop_t [3:0]           disp_op_o;
  logic [3:0][5:0]      disp_dst_o, disp_q1_o, disp_q2_o;
  logic [3:0][31:0]     disp_v1_o, disp_v2_o;
  logic [3:0]           disp_r1_o, disp_r2_o;
  logic [3:0]           count_o;

  int errors = 0;
  int checks = 0;
  logic [5:0] sb[$];

  dispatch_queue dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_op_i(enq_op_i), .enq_dst_i(enq_dst_i),
    .enq_v1_i(enq_v1_i), .enq_q1_i(enq_q1_i), .enq_r1_i(enq_r1_i),
    .enq_v2_i(enq_v2_i), .enq_q2_i(enq_q2_i), .enq_r2_i(enq_r2_i),
    .enq_ready_o(enq_ready_o),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_val_i(cdb_val_i),
    .rs_free_i(rs_free_i),
    .disp_valid_o(disp_valid_o), .disp_op_o(disp_op_o), .disp_dst_o(disp_dst_o),
    .disp_v1_o(disp_v1_o), .disp_q1_o(disp_q1_o), .disp_r1_o(disp_r1_o),
    .disp_v2_o(disp_v2_o), .disp_q2_o(disp_q2_o), .disp_r2_o(disp_r2_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    flush_i     = 0;
    enq_valid_i = '0;
    enq_op_i    = '0;
    enq_dst_i   = '0;
    enq_q1_i    = '0;
    enq_q2_i    = '0;
    enq_v1_i    = '0;
    enq_v2_i    = '0;
    enq_r1_i    = '0;
    enq_r2_i    = '0;
    cdb_valid_i = '0;
    cdb_tag_i   = '0;
    cdb_val_i   = '0;
    rs_free_i   = '0;
  endtask

  task automatic set_slot(input int k, input logic [5:0] dst,
                          input logic [31:0] v1, input logic [5:0] q1,
                          input logic r1, input logic [31:0] v2,
                          input logic [5:0] q2, input logic r2);
    enq_valid_i[k] = 1'b1;
    enq_op_i[k]    = uop_t'(14'(dst));
    enq_dst_i[k]   = dst;
    enq_v1_i[k]    = v1;
    enq_q1_i[k]    = q1;
    enq_r1_i[k]    = r1;
    enq_v2_i[k]    = v2;
    enq_q2_i[k]    = q2;
    enq_r2_i[k]    = r2;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 0;
    #12;
    checks++;
    if (enq_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b exp 1", enq_ready_o);
    end
    checks++;
    if (disp_valid_o !== 4'b0000) begin
      errors++; $display("FAIL rst_dvalid got %b exp 0000", disp_valid_o);
    end
    checks++;
    if (count_o !== 4'd0) begin
      errors++; $display("FAIL rst_count got %0d exp 0", count_o);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_basic();
    clear_in();
    rs_free_i = 16;
    for (int k = 0; k < 4; k++) set_slot(k, 6'(k + 1), 32'(k), 0, 1, 0, 0, 1);
    #1;
    checks++;
    if (disp_valid_o !== 4'b0000) begin
      errors++; $display("FAIL no_bypass got %b exp 0000", disp_valid_o);
    end
    tick();
    clear_in();
    rs_free_i = 16;
    #1;
    checks++;
    if (count_o !== 4'd4) begin
      errors++; $display("FAIL basic_count got %0d exp 4", count_o);
    end
    checks++;
    if (disp_valid_o !== 4'b1111) begin
      errors++; $display("FAIL basic_dvalid got %b exp 1111", disp_valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (disp_dst_o[k] !== 6'(k + 1)) begin
        errors++; $display("FAIL basic_dst%0d got %0d exp %0d", k, disp_dst_o[k], k + 1);
      end
    end
    tick();
    #1;
    checks++;
    if (count_o !== 4'd0) begin
      errors++; $display("FAIL basic_drain got %0d exp 0", count_o);
    end
  endtask

  task automatic test_fill_limit();
    clear_in();
    for (int k = 0; k < 4; k++) set_slot(k, 6'(10 + k), 0, 0, 1, 0, 0, 1);
    tick();
    clear_in();
    #1;
    checks++;
    if (count_o !== 4'd4 || enq_ready_o !== 1'b1) begin
      errors++; $display("FAIL fill4 got cnt=%0d rdy=%b exp cnt=4 rdy=1", count_o, enq_ready_o);
    end
    for (int k = 0; k < 4; k++) set_slot(k, 6'(14 + k), 0, 0, 1, 0, 0, 1);
    tick();
    clear_in();
    #1;
    checks++;
    if (count_o !== 4'd8 || enq_ready_o !== 1'b0) begin
      errors++; $display("FAIL fill8 got cnt=%0d rdy=%b exp cnt=8 rdy=0", count_o, enq_ready_o);
    end
    for (int k = 0; k < 4; k++) set_slot(k, 6'(30 + k), 0, 0, 1, 0, 0, 1);
    tick();
    clear_in();
    #1;
    checks++;
    if (count_o !== 4'd8) begin
      errors++; $display("FAIL full_reject got %0d exp 8", count_o);
    end
    rs_free_i = 2;
    #1;
    checks++;
    if (disp_valid_o !== 4'b0011) begin
      errors++; $display("FAIL rs2_dvalid got %b exp 0011", disp_valid_o);
    end
    checks++;
    if (disp_dst_o[0] !== 6'd10 || disp_dst_o[1] !== 6'd11) begin
      errors++; $display("FAIL rs2_dst got %0d,%0d exp 10,11", disp_dst_o[0], disp_dst_o[1]);
    end
    tick();
    checks++;
    if (count_o !== 4'd6 || disp_dst_o[0] !== 6'd12) begin
      errors++; $display("FAIL rs2_step1 got cnt=%0d dst=%0d exp 6,12", count_o, disp_dst_o[0]);
    end
    tick();
    checks++;
    if (count_o !== 4'd4 || enq_ready_o !== 1'b1) begin
      errors++; $display("FAIL rs2_step2 got cnt=%0d rdy=%b exp 4,1", count_o, enq_ready_o);
    end
    rs_free_i = 16;
    #1;
    checks++;
    if (disp_valid_o !== 4'b1111 || disp_dst_o[0] !== 6'd14 || disp_dst_o[3] !== 6'd17) begin
      errors++; $display("FAIL fill_tail got v=%b d0=%0d d3=%0d exp 1111,14,17",
                         disp_valid_o, disp_dst_o[0], disp_dst_o[3]);
    end
    tick();
    checks++;
    if (count_o !== 4'd0) begin
      errors++; $display("FAIL fill_empty got %0d exp 0", count_o);
    end
  endtask

  task automatic test_cdb_stored();
    clear_in();
    set_slot(0, 6'd20, 0, 6'd9, 0, 0, 6'd7, 0);
    tick();
    clear_in();
    cdb_valid_i  = 4'b0100;
    cdb_tag_i[2] = 6'd9;
    cdb_val_i[2] = 32'hDEAD_BEEF;
    tick();
    clear_in();
    rs_free_i = 1;
    #1;
    checks++;
    if (disp_valid_o !== 4'b0001 || disp_dst_o[0] !== 6'd20) begin
      errors++; $display("FAIL st_head got v=%b d=%0d exp 0001,20", disp_valid_o, disp_dst_o[0]);
    end
    checks++;
    if (disp_r1_o[0] !== 1'b1 || disp_v1_o[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL st_wake got r=%b v=%h exp 1,deadbeef", disp_r1_o[0], disp_v1_o[0]);
    end
    checks++;
    if (disp_r2_o[0] !== 1'b0) begin
      errors++; $display("FAIL st_nomatch got r2=%b exp 0", disp_r2_o[0]);
    end
    tick();
    clear_in();
    set_slot(0, 6'd21, 0, 6'd9, 0, 32'h55, 0, 1);
    tick();
    clear_in();
    cdb_valid_i  = 4'b1100;
    cdb_tag_i[2] = 6'd9;
    cdb_val_i[2] = 32'hDEAD_BEEF;
    cdb_tag_i[3] = 6'd9;
    cdb_val_i[3] = 32'h1234_5678;
    rs_free_i    = 1;
    #1;
    checks++;
    if (disp_valid_o !== 4'b0001 || disp_r1_o[0] !== 1'b1 || disp_v1_o[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL same_cyc got v=%b r=%b val=%h exp 0001,1,deadbeef",
                         disp_valid_o, disp_r1_o[0], disp_v1_o[0]);
    end
    tick();
    clear_in();
    #1;
    checks++;
    if (count_o !== 4'd0) begin
      errors++; $display("FAIL st_empty got %0d exp 0", count_o);
    end
  endtask

  task automatic test_cdb_enq();
    clear_in();
    set_slot(0, 6'd22, 32'd1, 0, 1, 0, 6'd5, 0);
    cdb_valid_i  = 4'b0001;
    cdb_tag_i[0] = 6'd5;
    cdb_val_i[0] = 32'hCAFE_F00D;
    rs_free_i    = 4;
    #1;
    checks++;
    if (disp_valid_o !== 4'b0000) begin
      errors++; $display("FAIL enq_nobyp got %b exp 0000", disp_valid_o);
    end
    tick();
    clear_in();
    rs_free_i = 4;
    #1;
    checks++;
    if (disp_valid_o !== 4'b0001 || disp_dst_o[0] !== 6'd22) begin
      errors++; $display("FAIL enq_head got v=%b d=%0d exp 0001,22", disp_valid_o, disp_dst_o[0]);
    end
    checks++;
    if (disp_r2_o[0] !== 1'b1 || disp_v2_o[0] !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL enq_wake got r=%b v=%h exp 1,cafef00d", disp_r2_o[0], disp_v2_o[0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] e;
    sb.delete();
    for (int cyc = 0; cyc < 4; cyc++) begin
      clear_in();
      rs_free_i = 16;
      if (cyc < 3) begin
        for (int k = 0; k < 4; k++) begin
          set_slot(k, 6'(40 + 4 * cyc + k), 0, 0, 1, 0, 0, 1);
          sb.push_back(6'(40 + 4 * cyc + k));
        end
      end
      #1;
      checks++;
      if (disp_valid_o !== ((cyc == 0) ? 4'b0000 : 4'b1111)) begin
        errors++; $display("FAIL wrap_valid c%0d got %b", cyc, disp_valid_o);
      end
      for (int k = 0; k < 4; k++) begin
        if (disp_valid_o[k]) begin
          e = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
          checks++;
          if (disp_dst_o[k] !== e) begin
            errors++; $display("FAIL wrap_dst c%0d s%0d got %0d exp %0d", cyc, k, disp_dst_o[k], e);
          end
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0 || count_o !== 4'd0) begin
      errors++; $display("FAIL wrap_loss got left=%0d cnt=%0d exp 0,0", sb.size(), count_o);
    end
  endtask

  task automatic test_flush_reset();
    clear_in();
    for (int k = 0; k < 4; k++) set_slot(k, 6'(50 + k), 0, 0, 1, 0, 0, 1);
    tick();
    clear_in();
    set_slot(0, 6'd54, 0, 0, 1, 0, 0, 1);
    set_slot(1, 6'd55, 0, 0, 1, 0, 0, 1);
    tick();
    clear_in();
    #1;
    checks++;
    if (count_o !== 4'd6) begin
      errors++; $display("FAIL pre_flush got %0d exp 6", count_o);
    end
    flush_i = 1;
    rs_free_i = 16;
    for (int k = 0; k < 4; k++) set_slot(k, 6'(60 + k), 0, 0, 1, 0, 0, 1);
    #1;
    checks++;
    if (disp_valid_o !== 4'b0000) begin
      errors++; $display("FAIL flush_dvalid got %b exp 0000", disp_valid_o);
    end
    tick();
    clear_in();
    rs_free_i = 16;
    #1;
    checks++;
    if (count_o !== 4'd0 || enq_ready_o !== 1'b1 || disp_valid_o !== 4'b0000) begin
      errors++; $display("FAIL post_flush got cnt=%0d rdy=%b v=%b exp 0,1,0000",
                         count_o, enq_ready_o, disp_valid_o);
    end
    clear_in();
    for (int k = 0; k < 4; k++) set_slot(k, 6'(k), 0, 0, 1, 0, 0, 1);
    tick();
    clear_in();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (count_o !== 4'd0 || enq_ready_o !== 1'b1) begin
      errors++; $display("FAIL async_rst got cnt=%0d rdy=%b exp 0,1", count_o, enq_ready_o);
    end
    #3;
    rst_n = 1;
    rs_free_i = 16;
    #1;
    checks++;
    if (disp_valid_o !== 4'b0000) begin
      errors++; $display("FAIL rst_empty got %b exp 0000", disp_valid_o);
    end
    tick();
    checks++;
    if (count_o !== 4'd0) begin
      errors++; $display("FAIL rst_after got %0d exp 0", count_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_limit();
    test_cdb_stored();
    test_cdb_enq();
    test_back_to_back();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
